dmem_responder: RTL

//   Data-memory responder for the MIPS datapath: the memory-side end of the CPU data port
//   (memwrite/dataadr/writedata). Accepts one load/store request at a time over a valid/ready

---
 rtl/dmem_pkg.sv | 60 ++++++
 rtl/dmem_lane_unit.sv | 40 ++++
 rtl/dmem_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   size_e    : access size encoding (SZ_RSVD behaves as a word)
//   state_e   : responder FSM states
//   req_t     : captured request
//   lane_en / lane_wbyte : per-byte-lane store selection (little-endian)
//   misaligned: alignment check used when DMEM_MISALIGN_TRAP_EN is defined
package dmem_pkg;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Byte lane written by a store of this size at this low address.
  // Half ignores lo[0], word ignores lo entirely (forced alignment).
  function automatic logic lane_en(size_e sz, logic [1:0] lo, int lane);
    case (sz)
      SZ_BYTE: return lo == 2'(lane);
      SZ_HALF: return lo[1] == lane[1];
      default: return 1'b1;
    endcase
  endfunction

  // Store data is right-aligned, so byte/half data replicate across lanes.
  function automatic logic [7:0] lane_wbyte(size_e sz, logic [31:0] wd, int lane);
    case (sz)
      SZ_BYTE: return wd[7:0];
      SZ_HALF: return lane[0] ? wd[15:8] : wd[7:0];
      default: return wd[lane*8 +: 8];
    endcase
  endfunction

  function automatic logic misaligned(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational lane steering for one 32-bit word.
//   size, uns, lo : access size, zero-extend flag, addr[1:0]
//   wdata         : right-aligned store data
//   rword         : current array word
//   nword, be     : merged store word and byte enables
//   rdata         : extended load result
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [31:0] nword,
  output logic [NUM_LANES-1:0] be,
  output logic [31:0] rdata
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign be[i] = lane_en(size, lo, i);
    assign nword[i*VEC_W +: VEC_W] = be[i] ? lane_wbyte(size, wdata, i)
                                           : rword[i*VEC_W +: VEC_W];
  end

  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    bsel  = rword[{lo, 3'b000} +: 8];
    hsel  = lo[1] ? rword[31:16] : rword[15:0];
    rdata = rword;
    case (size)
      SZ_BYTE: rdata = {{24{~uns & bsel[7]}}, bsel};
      SZ_HALF: rdata = {{16{~uns & hsel[15]}}, hsel};
      default: rdata = rword;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the CPU data port. One request at a
// time over valid/ready, WAIT_CYCLES wait states, then a one-cycle response.
//   clk, reset (sync, active low)
//   req_valid/req_ready, req_write, req_size, req_unsigned, req_addr, req_wdata
//   rsp_valid, rsp_rdata, rsp_err
// Optional: DMEM_MISALIGN_TRAP_EN - misaligned half/word accesses respond
// with rsp_err=1, rdata 0 and no array write. Undefined: low address bits
// are forced to alignment and rsp_err stays 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_e      state;
  logic [3:0]  cnt;
  req_t        cap, live, cur;
  logic [AW-1:0] idx;
  logic [31:0] rword, nword, ext;
  logic [NUM_LANES-1:0] be;
  logic        err, enter_resp;

  assign req_ready = (state == S_IDLE);

  assign live = '{write: req_write, size: size_e'(req_size), uns: req_unsigned,
                  addr: req_addr, wdata: req_wdata};

  // With zero wait states the array access happens on the accepting edge,
  // so the live inputs are used; otherwise the captured copy.
  assign cur   = (state == S_IDLE) ? live : cap;
  assign idx   = cur.addr[AW+1:2];
  assign rword = mem[idx];

  logic unused_addr_hi;
  assign unused_addr_hi = ^cur.addr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign err = misaligned(cur.size, cur.addr[1:0]);
`else
  assign err = 1'b0;
`endif

  assign enter_resp = ((state == S_IDLE) && req_valid && ZERO_WAIT) ||
                      ((state == S_WAIT) && (cnt == 4'd0));

  dmem_lane_unit u_lane (
    .size  (cur.size),
    .uns   (cur.uns),
    .lo    (cur.addr[1:0]),
    .wdata (cur.wdata),
    .rword (rword),
    .nword (nword),
    .be    (be),
    .rdata (ext)
  );

  logic unused_be;
  assign unused_be = ^be;

  // Array is not reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && cur.write && !err)
      mem[idx] <= nword;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      if (enter_resp) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_rdata <= (cur.write || err) ? 32'd0 : ext;
        rsp_err   <= err;
      end
      case (state)
        S_IDLE: if (req_valid) begin
          cap <= live;
          if (!ZERO_WAIT) begin
            state <= S_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        S_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
